// File: rtl/pll_reset_ce.sv
// rtl/pll_reset_ce.sv - PLL lock sequencer: holds core reset after lock, generates 6/3/1.5 MHz enables
// Enables free-run during HOLD so synchronous-reset logic still sees clock edges while held.
module pll_reset_ce #(
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       reset_req,
  output logic       sys_reset,
  output logic       ce_6m,
  output logic       ce_6m_n,
  output logic       ce_3m,
  output logic       ce_1p5m,
  output logic [7:0] lock_drops
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  logic        sync1_q, sync2_q;
  state_t      state_q, state_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]  div_q, div_d;
  logic        sys_reset_q, sys_reset_d;
  logic        ce_6m_q, ce_6m_d;
  logic        ce_6m_n_q, ce_6m_n_d;
  logic        ce_3m_q, ce_3m_d;
  logic        ce_1p5m_q, ce_1p5m_d;
  logic [7:0]  lock_drops_q, lock_drops_d;
  logic        drop;
  logic        en;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      hold_cnt_q   <= '0;
      div_q        <= '0;
      sys_reset_q  <= 1'b1;
      ce_6m_q      <= 1'b0;
      ce_6m_n_q    <= 1'b0;
      ce_3m_q      <= 1'b0;
      ce_1p5m_q    <= 1'b0;
      lock_drops_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      div_q        <= div_d;
      sys_reset_q  <= sys_reset_d;
      ce_6m_q      <= ce_6m_d;
      ce_6m_n_q    <= ce_6m_n_d;
      ce_3m_q      <= ce_3m_d;
      ce_1p5m_q    <= ce_1p5m_d;
      lock_drops_q <= lock_drops_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    lock_drops_d = lock_drops_q;
    drop         = 1'b0;

    // Loss of lock outranks everything, including a pending reset request.
    case (state_q)
      WAIT_LOCK: begin
        if (sync2_q) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (!sync2_q) begin
          state_d = WAIT_LOCK;
          drop    = 1'b1;
        end else if (reset_req) begin
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!sync2_q) begin
          state_d = WAIT_LOCK;
          drop    = 1'b1;
        end else if (reset_req) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (drop && (lock_drops_q != 8'hFF)) begin
      lock_drops_d = lock_drops_q + 8'd1;
    end

    // Gating on both current and next state keeps div at 0 for every WAIT_LOCK cycle
    // and starts the divider from 0 on the first HOLD cycle.
    en          = (state_d != WAIT_LOCK);
    div_d       = ((state_q == WAIT_LOCK) || !en) ? 4'd0 : div_q + 4'd1;
    ce_6m_d     = en && (div_q[1:0] == 2'd3);
    ce_6m_n_d   = en && (div_q[1:0] == 2'd1);
    ce_3m_d     = en && (div_q[2:0] == 3'd7);
    ce_1p5m_d   = en && (div_q == 4'd15);
    sys_reset_d = (state_d != RUN);
  end

  assign sys_reset  = sys_reset_q;
  assign ce_6m      = ce_6m_q;
  assign ce_6m_n    = ce_6m_n_q;
  assign ce_3m      = ce_3m_q;
  assign ce_1p5m    = ce_1p5m_q;
  assign lock_drops = lock_drops_q;

endmodule

// File: tb/tb_pll_reset_ce.sv
// tb/tb_pll_reset_ce.sv - bench for pll_reset_ce against an edge-count reference model
module tb_pll_reset_ce;
  localparam int H  = 16;
  localparam int MW = 0;
  localparam int MH = 1;
  localparam int MR = 2;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       reset_req;
  logic       sys_reset, ce_6m, ce_6m_n, ce_3m, ce_1p5m;
  logic [7:0] lock_drops;

  logic [12:0] dut_v;
  logic [12:0] exp_v;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference state: mode, synchronizer history, edge of lock entry and edge of release
  int m_mode;
  bit m_s1, m_s2;
  int m_start;
  int m_release;
  int m_drops;

  pll_reset_ce #(.HOLD_CYCLES(H)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .locked     (locked),
    .reset_req  (reset_req),
    .sys_reset  (sys_reset),
    .ce_6m      (ce_6m),
    .ce_6m_n    (ce_6m_n),
    .ce_3m      (ce_3m),
    .ce_1p5m    (ce_1p5m),
    .lock_drops (lock_drops)
  );

  always #5 clk_sys = ~clk_sys;

  assign dut_v = {sys_reset, ce_6m, ce_6m_n, ce_3m, ce_1p5m, lock_drops};

  task automatic model_reset();
    m_mode    = MW;
    m_s1      = 1'b0;
    m_s2      = 1'b0;
    m_start   = 0;
    m_release = 0;
    m_drops   = 0;
    exp_v     = {1'b1, 4'b0000, 8'd0};
  endtask

  task automatic model_edge();
    int  d;
    bit  e6, e6n, e3, e15;
    edge_n++;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_mode == MW) begin
        if (m_s2) begin
          m_mode    = MH;
          m_start   = edge_n;
          m_release = edge_n + H;
        end
      end else if (!m_s2) begin
        m_mode = MW;
        if (m_drops < 255) m_drops++;
      end else if (reset_req) begin
        m_mode    = MH;
        m_release = edge_n + H;
      end else if (m_mode == MH && edge_n == m_release) begin
        m_mode = MR;
      end
      m_s2 = m_s1;
      m_s1 = locked;
      {e6, e6n, e3, e15} = 4'b0000;
      if (m_mode != MW && edge_n > m_start) begin
        d   = (edge_n - 1 - m_start) % 16;
        e6  = (d % 4) == 3;
        e6n = (d % 4) == 1;
        e3  = (d % 8) == 7;
        e15 = d == 15;
      end
      exp_v = {(m_mode != MR), e6, e6n, e3, e15, 8'(m_drops)};
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    locked    = 1'b0;
    reset_req = 1'b0;
    #2 rst_n  = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_v !== 13'b1_0000_00000000) begin
      errors++;
      $display("FAIL reset_initial got %b exp %b", dut_v, 13'b1_0000_00000000);
    end
    locked = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (dut_v !== 13'b1_0000_00000000) begin
      errors++;
      $display("FAIL reset_held_locked got %b exp %b", dut_v, 13'b1_0000_00000000);
    end
    locked = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (dut_v !== exp_v) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", dut_v, exp_v);
    end
  endtask

  task automatic test_lockup();
    int n;
    locked = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL lockup_model edge %0d got %b exp %b", edge_n, dut_v, exp_v);
      end
    end while (sys_reset && n < 100);
    checks++;
    if (n !== 19) begin
      errors++;
      $display("FAIL lockup_latency got %0d edges exp 19", n);
    end
  endtask

  task automatic test_enable_pattern();
    int c6, c6n, c3, c15, bad_align, bad_gap, last6;
    c6 = 0; c6n = 0; c3 = 0; c15 = 0; bad_align = 0; bad_gap = 0; last6 = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL pattern_model edge %0d got %b exp %b", edge_n, dut_v, exp_v);
      end
      c6  += int'(ce_6m);
      c6n += int'(ce_6m_n);
      c3  += int'(ce_3m);
      c15 += int'(ce_1p5m);
      if ((ce_1p5m && !ce_3m) || (ce_3m && !ce_6m) || (ce_6m && ce_6m_n)) bad_align++;
      if (ce_6m) begin
        if (last6 >= 0 && (i - last6) != 4) bad_gap++;
        last6 = i;
      end
    end
    checks++;
    if ({c6, c6n, c3, c15} !== {32'd16, 32'd16, 32'd8, 32'd4}) begin
      errors++;
      $display("FAIL pattern_counts got %0d/%0d/%0d/%0d exp 16/16/8/4", c6, c6n, c3, c15);
    end
    checks++;
    if (bad_align !== 0 || bad_gap !== 0) begin
      errors++;
      $display("FAIL pattern_alignment got %0d align %0d gap errors exp 0", bad_align, bad_gap);
    end
  endtask

  task automatic test_lock_loss();
    logic [7:0] d0;
    d0 = lock_drops;
    checks++;
    if (sys_reset !== 1'b0) begin
      errors++;
      $display("FAIL lockloss_pre_run got %b exp 0", sys_reset);
    end
    locked = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({sys_reset, ce_6m, ce_6m_n, ce_3m, ce_1p5m} !== 5'b10000) begin
      errors++;
      $display("FAIL lockloss_outputs got %b exp 10000", {sys_reset, ce_6m, ce_6m_n, ce_3m, ce_1p5m});
    end
    checks++;
    if (lock_drops !== d0 + 8'd1) begin
      errors++;
      $display("FAIL lockloss_count got %0d exp %0d", lock_drops, d0 + 8'd1);
    end
    locked = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    d0 = lock_drops;
    #2 locked = 1'b0;
    #2 locked = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL glitch_model edge %0d got %b exp %b", edge_n, dut_v, exp_v);
      end
    end
    checks++;
    if ({sys_reset, lock_drops} !== {1'b0, d0}) begin
      errors++;
      $display("FAIL glitch_ignored got %b/%0d exp 0/%0d", sys_reset, lock_drops, d0);
    end
  endtask

  task automatic test_reset_req_hold();
    int n;
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    n = 0;
    while (sys_reset && n < 50) begin
      tick();
      n++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL reqhold_model edge %0d got %b exp %b", edge_n, dut_v, exp_v);
      end
    end
    checks++;
    if (n !== H) begin
      errors++;
      $display("FAIL reqhold_release got %0d edges exp %0d", n, H);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (locked) locked = ($urandom_range(199) != 0);
      else        locked = ($urandom_range(9) == 0);
      reset_req = ($urandom_range(39) == 0);
      tick();
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL random_model edge %0d got %b exp %b", edge_n, dut_v, exp_v);
      end
    end
    reset_req = 1'b0;
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 300; k++) begin
      locked = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      locked = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL sat_model loop %0d got %b exp %b", k, dut_v, exp_v);
      end
    end
    checks++;
    if (lock_drops !== 8'd255) begin
      errors++;
      $display("FAIL sat_final got %0d exp 255", lock_drops);
    end
  endtask

  task automatic test_async_reset();
    locked = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    checks++;
    if (sys_reset !== 1'b0) begin
      errors++;
      $display("FAIL async_pre_run got %b exp 0", sys_reset);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_v !== 13'b1_0000_00000000) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", dut_v, 13'b1_0000_00000000);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL async_relock edge %0d got %b exp %b", edge_n, dut_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lockup();
    test_enable_pattern();
    test_lock_loss();
    test_reset_req_hold();
    test_random();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_ce.md
PLL_RESET_CE -- requirements
Module: pll_reset_ce

Interface
REQ-001 The block SHALL have one parameter: HOLD_CYCLES, default 1024, the number of clk_sys cycles reset stays held after lock, legal range 2..65535.
REQ-002 clk_sys  input  1  system clock, the PLL 24 MHz output; the block's only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 locked  input  1  PLL lock indication, asynchronous to clk_sys.
REQ-005 reset_req  input  1  synchronous level request for a core reset, for example from the OSD or an ioctl download.
REQ-006 sys_reset  output  1  registered, active-high core reset.
REQ-007 ce_6m  output  1  single-cycle 6 MHz clock enable.
REQ-008 ce_6m_n  output  1  single-cycle 6 MHz enable, half a period after ce_6m.
REQ-009 ce_3m  output  1  single-cycle 3 MHz clock enable.
REQ-010 ce_1p5m  output  1  single-cycle 1.5 MHz clock enable.
REQ-011 lock_drops  output  8  saturating count of lock losses since rst_n.

Function
REQ-012 locked SHALL pass through a 2-flop synchronizer; locked_s is the output of the second flop.
REQ-013 The state machine SHALL have three states: WAIT_LOCK, HOLD and RUN.
REQ-014 WAIT_LOCK -> HOLD on the first edge where locked_s=1; on that edge hold_cnt loads 0.
REQ-015 In HOLD, hold_cnt (16-bit) SHALL increment every cycle; HOLD -> RUN on the edge where hold_cnt==HOLD_CYCLES-1.
REQ-016 In HOLD or RUN, locked_s=0 SHALL take priority and move the FSM to WAIT_LOCK on the next edge.
REQ-017 In RUN, reset_req=1 with locked_s=1 SHALL move the FSM to HOLD with hold_cnt=0.
REQ-018 In HOLD, reset_req=1 SHALL reload hold_cnt to 0, so release occurs HOLD_CYCLES cycles after reset_req last sampled high.
REQ-019 sys_reset SHALL be registered: 0 on the edge the FSM enters RUN, 1 on the edge it leaves RUN; it is 1 in all other states.
REQ-020 div (4-bit) SHALL be held at 0 in WAIT_LOCK and increment by 1 mod 16 every cycle in HOLD and RUN.
REQ-021 The enables SHALL be registered, asserted the cycle after the condition holds, and all 0 in WAIT_LOCK:
- ce_6m=1 when div[1:0]==3
- ce_6m_n=1 when div[1:0]==1
- ce_3m=1 when div[2:0]==7
- ce_1p5m=1 when div==15
REQ-022 Enable alignment SHALL hold: every ce_1p5m pulse coincides with ce_3m, and every ce_3m pulse coincides with ce_6m.
REQ-023 Enable spacing SHALL be ce_6m every 4 cycles, ce_3m every 8 and ce_1p5m every 16.
REQ-024 ce_6m and ce_6m_n SHALL never assert in the same cycle.
REQ-025 Enables SHALL keep running in HOLD so that synchronous-reset logic sees clock edges while reset is held.
REQ-026 lock_drops SHALL increment on each HOLD->WAIT_LOCK or RUN->WAIT_LOCK transition and saturate at 255.
REQ-027 A lock glitch shorter than one cycle that the synchronizer does not capture SHALL have no effect.

Reset
REQ-028 While rst_n=0, the block SHALL be in this state, asynchronously:
- FSM in WAIT_LOCK
- sys_reset=1
- all ce_* outputs 0
- div, hold_cnt and lock_drops at 0
- both synchronizer flops at 0
REQ-029 rst_n deassertion SHALL release the flops without further synchronization inside this block; the board-level reset is already synchronous to clk_sys.
REQ-030 rst_n asserted mid-operation SHALL force the REQ-028 state immediately, regardless of locked.

Verification
REQ-031 Lock-up: with HOLD_CYCLES=16, raise locked -> sys_reset falls 2+1+16 edges later (19th edge after the rise is sampled).
REQ-032 Enable pattern: over 64 cycles in RUN -> exactly 16 ce_6m, 16 ce_6m_n, 8 ce_3m and 4 ce_1p5m pulses, with the REQ-022 alignment and no ce_6m/ce_6m_n overlap.
REQ-033 Lock loss in RUN: drop locked -> sys_reset=1 and all enables 0 by the 3rd edge; lock_drops goes 0->1.
REQ-034 reset_req mid-HOLD: pulse reset_req at hold_cnt=10 with HOLD_CYCLES=16 -> release occurs 16 cycles after the pulse.
REQ-035 Saturation: 300 lock drop/relock cycles -> lock_drops=255.
REQ-036 Async reset in RUN: assert rst_n=0 between edges -> sys_reset=1 and all outputs at reset values before the next edge.
